// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame engine.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam int DATA_WIDTH_DEF = 8;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter, three-point majority sampler and bit-end strobe.
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  input  logic       start,
  input  logic       active,
  output logic       bit_val,
  output logic       bit_end
);

  logic [5:0] edge_cnt_q, edge_cnt_d;
  logic [2:0] samp_q, samp_d;
  logic [5:0] half_s;
  logic [5:0] last_s;

  assign half_s = {1'b0, prescale[5:1]};
  assign last_s = prescale - 6'd1;

  // The start-detect clock is edge 0 of the start bit, so counting resumes at 1.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    samp_d     = samp_q;
    if (start) begin
      edge_cnt_d = 6'd1;
    end else if (active) begin
      if (edge_cnt_q == last_s) begin
        edge_cnt_d = 6'd0;
      end else begin
        edge_cnt_d = edge_cnt_q + 6'd1;
      end
    end else begin
      edge_cnt_d = 6'd0;
    end
    if (edge_cnt_q == half_s - 6'd1) begin
      samp_d[0] = rx_in;
    end else if (edge_cnt_q == half_s) begin
      samp_d[1] = rx_in;
    end else if (edge_cnt_q == half_s + 6'd1) begin
      samp_d[2] = rx_in;
    end else begin
      samp_d = samp_q;
    end
  end

  // Counter and sample registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= 6'd0;
      samp_q     <= 3'b000;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      samp_q     <= samp_d;
    end
  end

  assign bit_val = majority3(samp_q);
  assign bit_end = active && (edge_cnt_q == last_s);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive frame engine: start detect, LSB-first data, optional parity, stop check.
module uart_rx_frame
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  rx_state_e             state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  par_flag_q, par_flag_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_error_q, parity_error_d;
  logic                  stop_error_q, stop_error_d;
  logic                  bit_val_s, bit_end_s;
  logic                  start_s, active_s;

  function automatic logic exp_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return odd ? ~(^d) : (^d);
  endfunction

  assign start_s  = (state_q == IDLE) && !rx_in;
  assign active_s = (state_q != IDLE);

  uart_rx_sampler u_sampler (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .prescale (prescale),
    .start    (start_s),
    .active   (active_s),
    .bit_val  (bit_val_s),
    .bit_end  (bit_end_s)
  );

  // Frame FSM: every decision is taken on the bit-end strobe using the majority value.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    p_data_d       = p_data_q;
    par_en_d       = par_en_q;
    par_type_d     = par_type_q;
    par_flag_d     = par_flag_q;
    data_valid_d   = 1'b0;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_in) begin
          state_d    = START;
          par_en_d   = parity_enable;
          par_type_d = parity_type;
          bit_cnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d = bit_val_s ? IDLE : DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_d[bit_cnt_q] = bit_val_s;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          par_flag_d = (bit_val_s != exp_parity(shift_q, par_type_q));
          state_d    = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          stop_error_d   = !bit_val_s;
          parity_error_d = par_flag_q;
          data_valid_d   = bit_val_s && !par_flag_q;
          if (data_valid_d) begin
            p_data_d = shift_q;
          end else begin
            p_data_d = p_data_q;
          end
          par_flag_d = 1'b0;
          state_d    = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      p_data_q       <= '0;
      par_en_q       <= 1'b0;
      par_type_q     <= 1'b0;
      par_flag_q     <= 1'b0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      p_data_q       <= p_data_d;
      par_en_q       <= par_en_d;
      par_type_q     <= par_type_d;
      par_flag_q     <= par_flag_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
    end
  end

  assign p_data       = p_data_q;
  assign data_valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign stop_error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: vector table plus glitch, back-to-back and reset sequences.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       parity_enable = 1'b0;
  logic       parity_type = 1'b0;
  logic [7:0] p_data;
  logic       data_valid, parity_error, stop_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         ev_cyc[$];
  logic [2:0] ev_flg[$];
  logic [7:0] ev_pd[$];

  uart_rx_frame #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_in         (rx_in),
    .prescale      (prescale),
    .parity_enable (parity_enable),
    .parity_type   (parity_type),
    .p_data        (p_data),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .stop_error    (stop_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every output pulse with the posedge index that registered it.
  always @(negedge clk) begin
    if (data_valid || parity_error || stop_error) begin
      ev_cyc.push_back(cyc);
      ev_flg.push_back({data_valid, parity_error, stop_error});
      ev_pd.push_back(p_data);
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       pty;
    logic       pbit;
    logic       sbit;
    logic [5:0] psc;
    logic       flip;
    logic [2:0] exp_flg;
    logic [7:0] exp_pd;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a posedge; leaves off just after the posedge ending the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic sbit, input logic [5:0] p, input logic flip,
                            output int start_edge);
    logic [11:0] fr;
    int n;
    fr = 12'hFFF;
    fr[0] = 1'b0;
    fr[8:1] = d;
    if (pen) begin
      fr[9] = pbit;
      fr[10] = sbit;
      n = 11;
    end else begin
      fr[9] = sbit;
      n = 10;
    end
    start_edge = cyc + 1;
    for (int i = 0; i < n; i++) begin
      rx_in = fr[i];
      repeat (int'(p)) begin
        @(posedge clk);
        #1;
      end
      if (flip && i == 0) begin
        parity_enable = ~parity_enable;
        parity_type   = ~parity_type;
      end
    end
    rx_in = 1'b1;
  endtask

  task automatic chk_event(input string name, input int idx, input logic [2:0] flg,
                           input logic [7:0] pd, input int st, input int lat);
    if (idx < ev_cyc.size()) begin
      chk({name, "_flags"}, int'(ev_flg[idx]), int'(flg));
      chk({name, "_pdata"}, int'(ev_pd[idx]), int'(pd));
      chk({name, "_latency"}, ev_cyc[idx] - st + 1, lat);
    end else begin
      chk({name, "_missing"}, 0, 1);
    end
  endtask

  initial begin
    int n0;
    int st;
    int st2;
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 6'd8,  1'b0, 3'b100, 8'hA5, 88};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 6'd8,  1'b0, 3'b010, 8'hA5, 88};
    vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 6'd16, 1'b0, 3'b001, 8'hA5, 160};
    vecs[3] = '{8'h96, 1'b1, 1'b1, 1'b1, 1'b1, 6'd32, 1'b0, 3'b100, 8'h96, 352};
    vecs[4] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 6'd16, 1'b0, 3'b011, 8'h96, 176};
    vecs[5] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8,  1'b1, 3'b100, 8'hC3, 80};

    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_p_data", int'(p_data), 0);
    chk("reset_data_valid", int'(data_valid), 0);
    chk("reset_parity_error", int'(parity_error), 0);
    chk("reset_stop_error", int'(stop_error), 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      prescale      = vecs[i].psc;
      parity_enable = vecs[i].pen;
      parity_type   = vecs[i].pty;
      @(posedge clk);
      #1;
      n0 = ev_cyc.size();
      send_frame(vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].sbit, vecs[i].psc,
                 vecs[i].flip, st);
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_count", i), ev_cyc.size() - n0, 1);
      chk_event($sformatf("vec%0d", i), n0, vecs[i].exp_flg, vecs[i].exp_pd, st,
                vecs[i].exp_lat);
    end

    // Start glitch: two low clocks must not produce a frame.
    prescale = 6'd16;
    parity_enable = 1'b0;
    @(posedge clk);
    #1;
    n0 = ev_cyc.size();
    rx_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("glitch_no_pulse", ev_cyc.size() - n0, 0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 6'd16, 1'b0, st);
    repeat (4) @(posedge clk);
    #1;
    chk("after_glitch_count", ev_cyc.size() - n0, 1);
    chk_event("after_glitch", n0, 3'b100, 8'h81, st, 160);

    // Back-to-back frames with no idle gap.
    prescale = 6'd32;
    @(posedge clk);
    #1;
    n0 = ev_cyc.size();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 6'd32, 1'b0, st);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 6'd32, 1'b0, st2);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_count", ev_cyc.size() - n0, 2);
    chk_event("b2b_first", n0, 3'b100, 8'h01, st, 320);
    chk_event("b2b_second", n0 + 1, 3'b100, 8'hFE, st2, 320);
    if (ev_cyc.size() >= n0 + 2) begin
      chk("b2b_spacing", ev_cyc[n0+1] - ev_cyc[n0], 320);
    end else begin
      chk("b2b_spacing_missing", 0, 1);
    end

    // Reset during data bit 4 of 0x7E, then a clean frame.
    prescale = 6'd8;
    @(posedge clk);
    #1;
    n0 = ev_cyc.size();
    rx_in = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int b = 0; b < 4; b++) begin
      rx_in = (b == 0) ? 1'b0 : 1'b1;
      repeat (8) @(posedge clk);
      #1;
    end
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_p_data", int'(p_data), 0);
    chk("midrst_data_valid", int'(data_valid), 0);
    chk("midrst_parity_error", int'(parity_error), 0);
    chk("midrst_stop_error", int'(stop_error), 0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 6'd8, 1'b0, st);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_count", ev_cyc.size() - n0, 1);
    chk_event("midrst_frame", n0, 3'b100, 8'h7E, st, 80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
